// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
//   Two-requester word arbiter feeding a UART character FIFO. A granted
//   32-bit word is split into WORD_BYTES bytes, MSB first, and pushed one
//   byte per cycle whenever the FIFO has room. Ties are broken by a
//   last-grant pointer, so continuous contention alternates 0,1,0,1.
//
//   Optional feature, macro TX_ARB_HDR_EN: prefix each word with a header
//   byte {HDR_BYTE[7:1], grant_id}. Without the macro there is no header
//   state and exactly WORD_BYTES bytes are written per word.
//
// Parameters
//   WORD_BYTES  bytes sent per accepted word (1..4)
//   HDR_BYTE    header template (only used with TX_ARB_HDR_EN)
//
// Ports
//   clk_tx       in   single clock, rising edge
//   rst_clk_tx   in   synchronous active-high reset
//   reqN_valid   in   requester N has a word
//   reqN_data    in   requester N word (32b)
//   reqN_ready   out  requester N word accepted this cycle (combinational)
//   fifo_full    in   char FIFO cannot take a write
//   fifo_din     out  byte to char FIFO (8'h00 when not writing)
//   fifo_wr_en   out  char FIFO push strobe
//   busy         out  FSM not in IDLE
//   grant_id     out  owner of the current word, valid while busy
// ---------------------------------------------------------------------------
module uart_tx_arb #(
  parameter int         WORD_BYTES = 4,
  parameter logic [7:0] HDR_BYTE   = 8'hA4
) (
  input  logic        clk_tx,
  input  logic        rst_clk_tx,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  input  logic        fifo_full,
  output logic [7:0]  fifo_din,
  output logic        fifo_wr_en,
  output logic        busy,
  output logic        grant_id
);

  localparam int NUM_REQ = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
`ifdef TX_ARB_HDR_EN
  localparam logic [1:0] ST_HDR  = 2'd2;
`endif

  // Index of the final data byte; the counter stops here and wraps to 0.
  localparam logic [2:0] LAST_IDX = 3'(WORD_BYTES - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;

  // Requesters gathered into packed arrays so ready/arb logic is uniform.
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0][31:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;

  assign req_valid = {req1_valid, req0_valid};
  assign req_data  = {req1_data, req0_data};

  logic idle;
  logic win;
  logic accept;
  logic sending;

  assign idle = (state_q == ST_IDLE);

  // Single valid requester wins outright; on a tie the one not served last.
  assign win = (&req_valid) ? ~last_q : req_valid[1];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rdy
      assign req_ready[gi] = idle && req_valid[gi] && (win == 1'(gi));
    end
  endgenerate

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign accept     = |req_ready;

  // Any byte-producing state; the FIFO sees a push whenever it has room.
`ifdef TX_ARB_HDR_EN
  assign sending = (state_q == ST_SEND) || (state_q == ST_HDR);
`else
  assign sending = (state_q == ST_SEND);
`endif

  assign fifo_wr_en = sending && !fifo_full;
  assign busy       = !idle;
  assign grant_id   = grant_q;

  always_comb begin
    fifo_din = 8'h00;
    if (fifo_wr_en) begin
`ifdef TX_ARB_HDR_EN
      if (state_q == ST_HDR) fifo_din = {HDR_BYTE[7:1], grant_q};
      else                   fifo_din = shift_q[31:24];
`else
      fifo_din = shift_q[31:24];
`endif
    end
  end

`ifndef TX_ARB_HDR_EN
  // Header template has no consumer in this build.
  logic unused_hdr;
  assign unused_hdr = ^HDR_BYTE;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d = req_data[win];
          grant_d = win;
          cnt_d   = 3'd0;
`ifdef TX_ARB_HDR_EN
          state_d = ST_HDR;
`else
          state_d = ST_SEND;
`endif
        end
      end
`ifdef TX_ARB_HDR_EN
      ST_HDR: begin
        if (!fifo_full) state_d = ST_SEND;
      end
`endif
      ST_SEND: begin
        // Stall entirely while the FIFO is full: nothing shifts or counts.
        if (!fifo_full) begin
          shift_d = {shift_q[23:0], 8'h00};
          if (cnt_q == LAST_IDX) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
            last_d  = grant_q;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_tx) begin
    if (rst_clk_tx) begin
      state_q <= ST_IDLE;
      shift_q <= 32'h0;
      cnt_q   <= 3'd0;
      grant_q <= 1'b0;
      // Pointer at 1 so requester 0 wins the first tie after reset.
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

  logic        clk_tx = 1'b0;
  logic        rst_clk_tx;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        fifo_full;
  logic [7:0]  fifo_din;
  logic        fifo_wr_en, busy, grant_id;

  // Second instance for the short-word configuration.
  logic        b_req0_valid;
  logic [31:0] b_req0_data;
  logic        b_req0_ready, b_req1_ready;
  logic [7:0]  b_fifo_din;
  logic        b_fifo_wr_en, b_busy, b_grant_id;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_tx = ~clk_tx;

  uart_tx_arb #(.WORD_BYTES(4), .HDR_BYTE(8'hA4)) u_dut (
    .clk_tx(clk_tx), .rst_clk_tx(rst_clk_tx),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .fifo_full(fifo_full), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
    .busy(busy), .grant_id(grant_id)
  );

  uart_tx_arb #(.WORD_BYTES(2), .HDR_BYTE(8'hA4)) u_dut2 (
    .clk_tx(clk_tx), .rst_clk_tx(rst_clk_tx),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
    .req1_valid(1'b0), .req1_data(32'h0), .req1_ready(b_req1_ready),
    .fifo_full(1'b0), .fifo_din(b_fifo_din), .fifo_wr_en(b_fifo_wr_en),
    .busy(b_busy), .grant_id(b_grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_tx);
    #1;
  endtask

  // Called just after the accept edge with fifo_full low. Checks every
  // byte on consecutive cycles, then the idle cycle that follows.
  task automatic expect_word(input string tag, input logic [31:0] w, input logic gid, input int nb);
    logic [31:0] sh;
    sh = w;
    #1;
`ifdef TX_ARB_HDR_EN
    chk({tag, ".hdr_we"}, fifo_wr_en, 1);
    chk({tag, ".hdr"}, fifo_din, {7'h52, gid});
    tick();
`endif
    for (int i = 0; i < nb; i++) begin
      chk($sformatf("%s.we%0d", tag, i), fifo_wr_en, 1);
      chk($sformatf("%s.b%0d", tag, i), fifo_din, sh[31:24]);
      chk($sformatf("%s.gid%0d", tag, i), grant_id, gid);
      chk($sformatf("%s.busy%0d", tag, i), busy, 1);
      chk($sformatf("%s.rdy%0d", tag, i), {req1_ready, req0_ready}, 0);
      sh = sh << 8;
      tick();
    end
    chk({tag, ".end_busy"}, busy, 0);
    chk({tag, ".end_we"}, fifo_wr_en, 0);
    chk({tag, ".end_din"}, fifo_din, 0);
  endtask

  task automatic do_reset();
    rst_clk_tx = 1'b1;
    tick();
    tick();
    rst_clk_tx = 1'b0;
  endtask

  initial begin
    rst_clk_tx = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0;
    fifo_full = 0; b_req0_valid = 0; b_req0_data = 0;

    // Reset state
    do_reset();
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.we", fifo_wr_en, 0);
    chk("rst.din", fifo_din, 0);
    chk("rst.gid", grant_id, 0);
    chk("rst.rdy", {req1_ready, req0_ready}, 0);

    // Single word from requester 0
    req0_valid = 1; req0_data = 32'h11223344;
    #1;
    chk("w0.rdy0", req0_ready, 1);
    chk("w0.rdy1", req1_ready, 0);
    tick();
    req0_valid = 0;
    expect_word("w0", 32'h11223344, 0, 4);

    // Continuous contention from reset: 0,1,0
    do_reset();
    req0_valid = 1; req0_data = 32'hAAAAAAAA;
    req1_valid = 1; req1_data = 32'h55555555;
    #1;
    chk("alt.rdy_a", {req1_ready, req0_ready}, 2'b01);
    tick();
    expect_word("alt0", 32'hAAAAAAAA, 0, 4);
    chk("alt.rdy_b", {req1_ready, req0_ready}, 2'b10);
    tick();
    expect_word("alt1", 32'h55555555, 1, 4);
    chk("alt.rdy_c", {req1_ready, req0_ready}, 2'b01);
    tick();
    req0_valid = 0; req1_valid = 0;
    expect_word("alt2", 32'hAAAAAAAA, 0, 4);

    // Back-pressure after the second data byte
    req0_valid = 1; req0_data = 32'h01020304;
    tick();
    req0_valid = 0;
`ifdef TX_ARB_HDR_EN
    #1; chk("bp.hdr", fifo_din, 8'hA4); tick();
`endif
    #1; chk("bp.b0", fifo_din, 8'h01); tick();
    #1; chk("bp.b1", fifo_din, 8'h02); tick();
    fifo_full = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp.stall_we%0d", i), fifo_wr_en, 0);
      chk($sformatf("bp.stall_din%0d", i), fifo_din, 0);
      chk($sformatf("bp.stall_busy%0d", i), busy, 1);
      tick();
    end
    fifo_full = 0;
    #1; chk("bp.b2_we", fifo_wr_en, 1); chk("bp.b2", fifo_din, 8'h03); tick();
    #1; chk("bp.b3", fifo_din, 8'h04); tick();
    #1; chk("bp.end_busy", busy, 0); chk("bp.end_we", fifo_wr_en, 0);

    // Reset mid-word; last_grant is now 0 so only a proper reset favours 0
    req0_valid = 1; req0_data = 32'h99887766;
    tick();
    req0_valid = 0;
`ifdef TX_ARB_HDR_EN
    tick();
`endif
    #1; chk("mr.b0", fifo_din, 8'h99); tick();
    #1; chk("mr.b1", fifo_din, 8'h88);
    rst_clk_tx = 1;
    tick();
    rst_clk_tx = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mr.we%0d", i), fifo_wr_en, 0);
      chk($sformatf("mr.busy%0d", i), busy, 0);
      tick();
    end
    req0_valid = 1; req1_valid = 1;
    req0_data = 32'h0A0B0C0D; req1_data = 32'hFFFFFFFF;
    #1;
    chk("mr.tie", {req1_ready, req0_ready}, 2'b01);
    tick();
    req0_valid = 0; req1_valid = 0;
    expect_word("mr.w", 32'h0A0B0C0D, 0, 4);

    // Requester 1 alone
    req1_valid = 1; req1_data = 32'hDEADBEEF;
    #1;
    chk("r1.rdy", {req1_ready, req0_ready}, 2'b10);
    tick();
    req1_valid = 0;
    expect_word("r1", 32'hDEADBEEF, 1, 4);

    // Two-byte words on the second instance
    b_req0_valid = 1; b_req0_data = 32'hCAFE0000;
    #1;
    chk("wb2.rdy", b_req0_ready, 1);
    tick();
    b_req0_valid = 0;
`ifdef TX_ARB_HDR_EN
    #1; chk("wb2.hdr", b_fifo_din, 8'hA4); tick();
`endif
    #1; chk("wb2.b0_we", b_fifo_wr_en, 1); chk("wb2.b0", b_fifo_din, 8'hCA); tick();
    #1; chk("wb2.b1_we", b_fifo_wr_en, 1); chk("wb2.b1", b_fifo_din, 8'hFE); tick();
    #1; chk("wb2.end_busy", b_busy, 0); chk("wb2.end_we", b_fifo_wr_en, 0);
    chk("wb2.gid", b_grant_id, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter: WORD_BYTES, default 4, number of bytes sent per accepted word (legal 1..4).
REQ-002 Parameter: HDR_BYTE, default 8'hA4, header template used only when TX_ARB_HDR_EN is defined.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: clk_tx  in  1  the single clock; all state updates on its rising edge.
REQ-005 Port: rst_clk_tx  in  1  synchronous, active-high reset.
REQ-006 Port: req0_valid  in  1  requester 0 has a word.
REQ-007 Port: req0_data  in  32  requester 0 word; bytes sent MSB first.
REQ-008 Port: req0_ready  out  1  requester 0 word accepted this cycle.
REQ-009 Port: req1_valid, req1_data, req1_ready  same widths and meanings as requester 0.
REQ-010 Port: fifo_full  in  1  char FIFO cannot accept a write.
REQ-011 Port: fifo_din  out  8  byte to the char FIFO.
REQ-012 Port: fifo_wr_en  out  1  char FIFO push strobe.
REQ-013 Port: busy  out  1  high whenever the state is not IDLE.
REQ-014 Port: grant_id  out  1  requester owning the current word; valid while busy.

Function
REQ-015 The FSM SHALL have states IDLE, HDR and SEND; HDR is reachable only with TX_ARB_HDR_EN.
REQ-016 In IDLE, the winner SHALL be the valid requester if only one is valid; if both are valid, the one not served last (last_grant pointer).
REQ-017 reqN_ready SHALL be combinational: high only in IDLE for the winner with reqN_valid high. At most one ready is high per cycle.
REQ-018 On accept, the block SHALL capture reqN_data into a 32-bit shift register and register grant_id. The next state is HDR (macro on) or SEND (macro off).
REQ-019 In HDR and SEND, fifo_wr_en SHALL equal !fifo_full (combinational); no state change or byte advance occurs while fifo_full is high.
REQ-020 In SEND, fifo_din SHALL equal shift_reg[31:24]; each write shifts the register left 8 bits and increments a byte counter.
REQ-021 After the WORD_BYTES-th write, the FSM SHALL return to IDLE, clear the byte counter and set last_grant to grant_id.
REQ-022 Latency: a word accepted at cycle N SHALL produce its first write no earlier than cycle N+1. The earliest next accept is the cycle after the last write, giving one idle cycle between words.
REQ-023 fifo_din SHALL be 8'h00 whenever fifo_wr_en is low.
REQ-024 No requester SHALL be accepted while busy is high; a deasserted valid in IDLE is simply not granted (no latching of stale requests).
REQ-025 With both requesters continuously valid, grants SHALL strictly alternate 0,1,0,1.

Reset
REQ-026 On rst_clk_tx, the block SHALL enter IDLE and clear the byte counter, shift register and grant_id. last_grant SHALL be set to 1 so that requester 0 wins the first tie.
REQ-027 Reset outputs: req0_ready=0, req1_ready=0, fifo_wr_en=0, fifo_din=8'h00, busy=0, grant_id=0.
REQ-028 Reset mid-word SHALL abandon remaining bytes with no further writes; the first tie after reset again favours requester 0.

Configuration
REQ-029 Macro TX_ARB_HDR_EN: when defined, the HDR state SHALL write one byte {HDR_BYTE[7:1], grant_id} (subject to fifo_full) before the data bytes, making WORD_BYTES+1 writes per word.
REQ-030 Without TX_ARB_HDR_EN, the block SHALL have no HDR state and SHALL write exactly WORD_BYTES bytes per word.

Verification
REQ-031 Macro off, fifo_full=0, req0 word 32'h11223344 -> writes 11,22,33,44 on four consecutive cycles starting 1 cycle after req0_ready; busy falls after the last write.
REQ-032 Both valid continuously from reset, req0=32'hAAAAAAAA, req1=32'h55555555 -> grant order 0,1,0,1; byte stream AA×4, 55×4, AA×4.
REQ-033 fifo_full held high for 3 cycles after the second byte -> fifo_wr_en low for those cycles, third byte held stable, no byte lost or duplicated.
REQ-034 Reset asserted after the second of four bytes -> no further fifo_wr_en; next simultaneous request grants requester 0.
REQ-035 Macro on, HDR_BYTE=8'hA4, req1 word 32'hDEADBEEF -> writes A5,DE,AD,BE,EF.
REQ-036 WORD_BYTES=2, req0 word 32'hCAFE0000 -> writes CA,FE only, then IDLE.
